// File: rtl/sub_seq_nbit.sv
// Multi-cycle subtractor d = a - b - bin, DIGIT bits per clock, with valid/ready handshakes.
// Optional macro SUB_SAT_EN: saturate d to the signed limit on overflow.
module sub_seq_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh;
    logic [WIDTH-1:0] r_next, d_fin;
    logic             borrow;
    logic [CW-1:0]    cnt;
    logic             a_msb, b_msb;
    logic [DIGIT:0]   diff;
    logic             last;
    logic             ovf_fin;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign last      = (cnt == CW'(STEPS - 1));

    // The extra top bit of diff is the borrow out of this digit.
    assign diff    = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - (DIGIT+1)'(borrow);
    assign r_next  = (r_sh >> DIGIT) | (WIDTH'(diff[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign ovf_fin = (a_msb ^ b_msb) & (a_msb ^ r_next[WIDTH-1]);

`ifdef SUB_SAT_EN
    assign d_fin = !ovf_fin ? r_next :
                   a_msb    ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign d_fin = r_next;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            d      <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh   <= a;
                    b_sh   <= b;
                    r_sh   <= '0;
                    borrow <= bin;
                    cnt    <= '0;
                    a_msb  <= a[WIDTH-1];
                    b_msb  <= b[WIDTH-1];
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    r_sh   <= r_next;
                    borrow <= diff[DIGIT];
                    cnt    <= cnt + 1'b1;
                    // Result flags are visible only from DONE onward and held until the next run ends.
                    if (last) begin
                        d    <= d_fin;
                        bout <= diff[DIGIT];
                        ovf  <= ovf_fin;
                        zero <= (d_fin == '0);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_seq_nbit.sv
// Self-checking bench for sub_seq_nbit: directed cases, randomized traffic against an
// arithmetic reference model, and an exhaustive sweep of a WIDTH=2 instance.
module tb_sub_seq_nbit #(
    parameter int DIGIT = 1
);
    localparam int WIDTH = 8;
    localparam int STEPS = WIDTH / DIGIT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, bin = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, out_valid, bout, ovf, zero;
    logic [7:0] d;

    logic       w2_in_valid = 1'b0, w2_out_ready = 1'b0, w2_bin = 1'b0;
    logic [1:0] w2_a = '0, w2_b = '0;
    logic       w2_in_ready, w2_out_valid, w2_bout, w2_ovf, w2_zero;
    logic [1:0] w2_d;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sub_seq_nbit #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .d(d), .bout(bout), .ovf(ovf), .zero(zero)
    );

    sub_seq_nbit #(.WIDTH(2), .DIGIT(1)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
        .a(w2_a), .b(w2_b), .bin(w2_bin), .out_valid(w2_out_valid), .out_ready(w2_out_ready),
        .d(w2_d), .bout(w2_bout), .ovf(w2_ovf), .zero(w2_zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers: unsigned borrow and true signed range overflow.
    function automatic void ref_sub(input int w, input int av, input int bv, input int bi,
                                    output int dv, output bit bo, output bit ov, output bit zr);
        int diff, sa, sb, s, half;
        half = 1 << (w - 1);
        diff = av - bv - bi;
        dv   = diff & ((1 << w) - 1);
        bo   = (diff < 0);
        sa   = (av >= half) ? av - (1 << w) : av;
        sb   = (bv >= half) ? bv - (1 << w) : bv;
        s    = sa - sb - bi;
        ov   = (s > half - 1) || (s < -half);
`ifdef SUB_SAT_EN
        if (ov) dv = (sa < 0) ? half : half - 1;
`endif
        zr   = (dv == 0);
    endfunction

    // Transaction-level model: one pending operation stamped with its accept cycle.
    int   cyc = 0, t_acc = 0;
    bit   m_busy = 1'b0;
    int   m_d = 0, p_d = 0;
    bit   m_bout = 1'b0, m_ovf = 1'b0, m_zero = 1'b0;
    bit   p_bout, p_ovf, p_zero;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_d = 0; m_bout = 1'b0; m_ovf = 1'b0; m_zero = 1'b0;
        end else begin
            cyc++;
            if (m_busy) begin
                if (cyc == t_acc + STEPS) begin
                    m_d = p_d; m_bout = p_bout; m_ovf = p_ovf; m_zero = p_zero;
                end else if (cyc > t_acc + STEPS && out_ready) begin
                    m_busy = 1'b0;
                end
            end else if (in_valid) begin
                m_busy = 1'b1;
                t_acc  = cyc;
                ref_sub(WIDTH, int'(a), int'(b), int'(bin), p_d, p_bout, p_ovf, p_zero);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            check("cmp_in_ready",  in_ready,  !m_busy);
            check("cmp_out_valid", out_valid, m_busy && (cyc >= t_acc + STEPS));
            check("cmp_d",         d,         m_d);
            check("cmp_bout",      bout,      m_bout);
            check("cmp_ovf",       ovf,       m_ovf);
            check("cmp_zero",      zero,      m_zero);
        end
    end

    // Issue one operation and wait (bounded) for out_valid; leaves the unit in DONE.
    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic bi, output int lat);
        @(negedge clk);
        a = av; b = bv; bin = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ready_after_handshake", in_ready, 1'b1);
        check("valid_after_handshake", out_valid, 1'b0);
    endtask

    task automatic run_case(input string name, input logic [7:0] av, input logic [7:0] bv,
                            input logic bi, input logic [7:0] exp_d, input logic exp_bout,
                            input logic exp_ovf, input logic exp_zero);
        int lat;
        issue(av, bv, bi, lat);
        check({name, "_latency"}, lat, STEPS);
        check({name, "_d"},    d,    exp_d);
        check({name, "_bout"}, bout, exp_bout);
        check({name, "_ovf"},  ovf,  exp_ovf);
        check({name, "_zero"}, zero, exp_zero);
        release_result();
    endtask

    initial begin
        int  lat, k, ed;
        bit  eb, eo, ez;
        logic [7:0] held;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_d", d, 8'h00);
        check("reset_flags", {bout, ovf, zero}, 3'b000);

        // Hand-computed literals pin both the DUT and the model.
        run_case("sub_5_3",    8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        run_case("wrap_0_1",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
        run_case("zero_10_0f", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef SUB_SAT_EN
        run_case("ovf_80_01",  8'h80, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_case("ovf_7f_ff",  8'h7F, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
`else
        run_case("ovf_80_01",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
        run_case("ovf_7f_ff",  8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
`endif

        // Backpressure: result held and new requests ignored while out_ready is low.
        issue(8'h33, 8'h11, 1'b1, lat);
        check("bp_latency", lat, STEPS);
        check("bp_d", d, 8'h21);
        held = d;
        repeat (5) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_hold_d", d, held);
            check("bp_hold_flags", {bout, ovf, zero}, 3'b000);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_result();
        check("bp_d_after", d, 8'h21);

        // Asynchronous reset during the third RUN cycle.
        @(negedge clk);
        a = 8'h44; b = 8'h01; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 1'b0);
        check("rst_mid_d", d, 8'h00);
        check("rst_mid_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_case("after_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

        // Randomized traffic; the compare process checks every cycle against the model.
        repeat (3000) begin
            @(negedge clk);
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            in_valid  = ($urandom_range(0, 2) == 0);
            out_ready = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (STEPS + 3) @(negedge clk);
        out_ready = 1'b0;

        // Exhaustive WIDTH=2 sweep.
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    @(negedge clk);
                    w2_a = 2'(av); w2_b = 2'(bv); w2_bin = 1'(bi); w2_in_valid = 1'b1;
                    @(posedge clk); #1;
                    w2_in_valid = 1'b0;
                    k = 0;
                    while (!w2_out_valid && k < 20) begin
                        @(posedge clk); #1;
                        k++;
                    end
                    ref_sub(2, av, bv, bi, ed, eb, eo, ez);
                    check("w2_latency", k, 2);
                    check("w2_d", w2_d, ed);
                    check("w2_flags", {w2_bout, w2_ovf, w2_zero}, {eb, eo, ez});
                    @(negedge clk);
                    w2_out_ready = 1'b1;
                    @(posedge clk); #1;
                    w2_out_ready = 1'b0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
